// File: rtl/camera_rot_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// camera_rot_ctrl_pkg
// Shared types and constants for the camera rotation controller and its
// neighbours (camera_rotator, ray generator).
//   float_t     : IEEE-754 single-precision bit pattern
//   vector_t    : packed {x, y, z} vector of float_t
//   FP_*        : the only component values that occur on the rotation lattice
//   KEY_*       : rotation key codes from the keyboard decoder
//   cam_state_t : controller FSM states
// -----------------------------------------------------------------------------
package camera_rot_ctrl_pkg;

    typedef logic [31:0] float_t;
    typedef logic [3:0]  key_t;

    typedef struct packed {
        float_t x;
        float_t y;
        float_t z;
    } vector_t;

    localparam float_t FP_0   = 32'h0000_0000;
    localparam float_t FP_1   = 32'h3F80_0000;
    localparam float_t FP_N1  = 32'hBF80_0000;
    localparam float_t FP_R2  = 32'h3F35_04F3;  //  1/sqrt(2)
    localparam float_t FP_NR2 = 32'hBF35_04F3;  // -1/sqrt(2)

    localparam key_t KEY_L = 4'd6;
    localparam key_t KEY_J = 4'd7;
    localparam key_t KEY_O = 4'd8;
    localparam key_t KEY_U = 4'd9;
    localparam key_t KEY_I = 4'd10;
    localparam key_t KEY_K = 4'd11;

    localparam vector_t U_INIT = {FP_1, FP_0, FP_0};
    localparam vector_t V_INIT = {FP_0, FP_1, FP_0};
    localparam vector_t W_INIT = {FP_0, FP_0, FP_1};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROT   = 2'd1,
        FRAME = 2'd2
    } cam_state_t;

    // Rotation keys occupy the contiguous range L..K; everything else is a
    // translation key handled elsewhere.
    function automatic logic is_rot_key(key_t k);
        return (k >= KEY_L) && (k <= KEY_K);
    endfunction

    // The rotator signals an off-lattice result by returning an all-zero vector.
    function automatic logic is_zero_vec(vector_t v);
        return (v.x == FP_0) && (v.y == FP_0) && (v.z == FP_0);
    endfunction

endpackage

// File: rtl/camera_rot_ctrl_key_fifo.sv
// -----------------------------------------------------------------------------
// key_fifo
// Small FIFO holding rotation key codes until the controller can serve them.
//   clk, rst   : clock, asynchronous active-high reset
//   push_i     : write data_i (ignored when full unless a pop happens too)
//   pop_i      : remove the head entry (ignored when empty)
//   data_i     : key code to enqueue
//   data_o     : key code at the head of the queue
//   full_o     : DEPTH entries held
//   empty_o    : no entries held
// DEPTH must be a power of two so the pointers wrap by plain overflow.
// -----------------------------------------------------------------------------
module key_fifo
    import camera_rot_ctrl_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic push_i,
    input  logic pop_i,
    input  key_t data_i,
    output key_t data_o,
    output logic full_o,
    output logic empty_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    key_t          mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_FULL);
    assign data_o  = mem_q[rd_ptr_q];

    // A pop in the same cycle frees the slot, so a push into a full queue is
    // still accepted then.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    // NOTE: every variable assigned in a combinational block gets a default
    // first, otherwise a path that skips the assignment infers a latch.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is deliberately left out of reset; an entry is only ever
    // read after it has been written, and the count register guards that.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/camera_rot_ctrl.sv
// -----------------------------------------------------------------------------
// camera_rot_ctrl
// Owns the committed camera basis U/V/W, queues rotation keys, drives one key
// at a time into the external camera_rotator and commits its result only
// between frames. Also grants frame starts to the ray generator.
//   clk, rst                  : clock, asynchronous active-high reset
//   key, key_valid            : key code + one-cycle strobe from the decoder
//   frame_req                 : level request from the renderer
//   frame_done                : one-cycle pulse, current frame finished
//   rot_valid, rot_{U,V,W}_n  : result from camera_rotator
//   rot_key, rot_{U,V,W}      : operands driven into camera_rotator
//   U, V, W                   : committed basis for the ray generator
//   frame_gnt                 : one-cycle grant, frame starts next cycle
//   in_frame                  : frame in progress
//   cam_update/key_drop/rot_err : one-cycle status pulses
// -----------------------------------------------------------------------------
module camera_rot_ctrl
    import camera_rot_ctrl_pkg::*;
#(
    parameter int KQ_DEPTH = 4
) (
    input  logic    clk,
    input  logic    rst,
    input  key_t    key,
    input  logic    key_valid,
    input  logic    frame_req,
    input  logic    frame_done,
    input  logic    rot_valid,
    input  vector_t rot_U_n,
    input  vector_t rot_V_n,
    input  vector_t rot_W_n,
    output key_t    rot_key,
    output vector_t rot_U,
    output vector_t rot_V,
    output vector_t rot_W,
    output vector_t U,
    output vector_t V,
    output vector_t W,
    output logic    frame_gnt,
    output logic    in_frame,
    output logic    cam_update,
    output logic    key_drop,
    output logic    rot_err
);

    cam_state_t state_q, state_d;
    vector_t    u_q, u_d, v_q, v_d, w_q, w_d;
    key_t       rot_key_q, rot_key_d;
    logic       after_rot_q;
    logic       cam_update_q, key_drop_q, rot_err_q;

    logic       key_accept, fifo_pop, fifo_full, fifo_empty;
    key_t       fifo_head;
    logic       take_rot, rot_ok, rot_commit, rot_reject;

    assign key_accept = key_valid && is_rot_key(key);

    key_fifo #(
        .DEPTH (KQ_DEPTH)
    ) u_key_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (key_accept),
        .pop_i   (fifo_pop),
        .data_i  (key),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Keys normally win over frames, except on the IDLE cycle right after a
    // rotation: a waiting frame goes first so rotations cannot starve frames.
    assign take_rot = !fifo_empty && !(frame_req && after_rot_q);

    assign rot_ok = rot_valid && !is_zero_vec(rot_U_n)
                              && !is_zero_vec(rot_V_n)
                              && !is_zero_vec(rot_W_n);

    // ---------------- state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (take_rot)       state_d = ROT;
                else if (frame_req) state_d = FRAME;
            end
            ROT:     state_d = IDLE;
            FRAME:   if (frame_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---------------- output / control decode ----------------
    always_comb begin
        fifo_pop   = 1'b0;
        frame_gnt  = 1'b0;
        in_frame   = 1'b0;
        rot_commit = 1'b0;
        rot_reject = 1'b0;
        case (state_q)
            IDLE: begin
                fifo_pop  = take_rot;
                frame_gnt = !take_rot && frame_req;
            end
            ROT: begin
                rot_commit = rot_ok;
                rot_reject = !rot_ok;
            end
            FRAME:   in_frame = 1'b1;
            default: ;
        endcase
    end

    // ---------------- datapath ----------------
    always_comb begin
        u_d       = rot_commit ? rot_U_n : u_q;
        v_d       = rot_commit ? rot_V_n : v_q;
        w_d       = rot_commit ? rot_W_n : w_q;
        // Non-zero only during ROT, which always follows the popping IDLE cycle.
        rot_key_d = fifo_pop ? fifo_head : 4'd0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            u_q          <= U_INIT;
            v_q          <= V_INIT;
            w_q          <= W_INIT;
            rot_key_q    <= 4'd0;
            after_rot_q  <= 1'b0;
            cam_update_q <= 1'b0;
            key_drop_q   <= 1'b0;
            rot_err_q    <= 1'b0;
        end else begin
            u_q          <= u_d;
            v_q          <= v_d;
            w_q          <= w_d;
            rot_key_q    <= rot_key_d;
            after_rot_q  <= (state_q == ROT);
            cam_update_q <= rot_commit;
            key_drop_q   <= key_accept && fifo_full && !fifo_pop;
            rot_err_q    <= rot_reject;
        end
    end

    assign rot_key    = rot_key_q;
    assign rot_U      = u_q;
    assign rot_V      = v_q;
    assign rot_W      = w_q;
    assign U          = u_q;
    assign V          = v_q;
    assign W          = w_q;
    assign cam_update = cam_update_q;
    assign key_drop   = key_drop_q;
    assign rot_err    = rot_err_q;

endmodule

// File: doc/camera_rot_ctrl.md
Name: camera_rot_ctrl

Overview:
- Sequences the combinational camera rotator against the frame renderer.
- Owns the camera basis registers U, V, W and queues rotation key events from the keyboard decoder.
- Drives one queued key at a time into an external camera_rotator and commits the result only between frames, so a frame never sees a half-updated basis.
- Also grants frame starts to the ray generator.

Parameters:
- KQ_DEPTH, 4, depth of the rotation-key FIFO; power of two, at least 2.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- key  in  4  key code from keyboard decoder; only valid when key_valid is high.
- key_valid  in  1  one-cycle strobe qualifying key.
- frame_req  in  1  renderer requests to start a frame; level, held until frame_gnt.
- frame_done  in  1  one-cycle pulse: renderer finished the current frame.
- rot_valid  in  1  from camera_rotator: driven key is a rotation key.
- rot_U_n, rot_V_n, rot_W_n  in  vector_t each  rotated basis from camera_rotator.
- rot_key  out  4  key driven into camera_rotator.
- rot_U, rot_V, rot_W  out  vector_t each  basis driven into camera_rotator; always equal to U, V, W.
- U, V, W  out  vector_t each  committed camera basis, read by the ray generator.
- frame_gnt  out  1  one-cycle grant; the frame starts the next cycle.
- in_frame  out  1  high from the cycle after frame_gnt until the cycle after frame_done.
- cam_update  out  1  one-cycle pulse: basis changed.
- key_drop  out  1  one-cycle pulse: key lost because the FIFO was full.
- rot_err  out  1  one-cycle pulse: rotation rejected because the rotator returned an off-lattice (zero) vector.

Behaviour:
- Reset values (async, immediate):
  - U = {FP_1,FP_0,FP_0}; V = {FP_0,FP_1,FP_0}; W = {FP_0,FP_0,FP_1}.
  - FIFO empty; state IDLE; rot_key = 4'd0.
  - frame_gnt, in_frame, cam_update, key_drop and rot_err all 0.
- Key filter: enqueue only when key_valid is high and 6 <= key <= 11. All other codes (translation keys 0-5, 12-15) are ignored; key_drop is not asserted for them.
- FIFO:
  - Push when full: key discarded, key_drop pulses the next cycle.
  - Push and pop in the same cycle while full: push accepted.
  - Pointers wrap modulo KQ_DEPTH; a separate count register distinguishes full from empty.
- FSM states: IDLE, ROT, FRAME.
  - IDLE, FIFO non-empty: pop the head into rot_key; go to ROT. Rotation has priority over frame_req.
  - IDLE, FIFO empty and frame_req high: assert frame_gnt for one cycle; go to FRAME.
  - ROT (exactly 1 cycle): sample rot_valid and rot_*_n at the end of the cycle.
    - rot_valid high and none of rot_U_n, rot_V_n, rot_W_n all-FP_0: load U, V, W; cam_update pulses the next cycle.
    - Otherwise: U, V, W unchanged; rot_err pulses the next cycle.
    - Next state IDLE; rot_key returns to 0.
  - Fairness: after a ROT, the following IDLE cycle serves a pending frame_req before popping another key. At most one rotation occurs between consecutive frames while frames are pending.
  - FRAME: U, V, W frozen; keys still enqueue. On frame_done go to IDLE; in_frame drops the cycle after frame_done.
- Latency: key_valid at cycle t, FIFO empty, state IDLE, no frame pending: pop at t+1, ROT at t+2, U/V/W and cam_update visible at t+3.
- frame_done outside FRAME is ignored.
- frame_req dropping before grant is legal; no grant is issued.
- rst asserted mid-ROT or mid-FRAME: everything returns to reset values; a partial rotation is never committed.

Decomposition:
- Shared package holds: vector_t, float_t, the FP_0/FP_1/FP_N1/FP_R2/FP_NR2 constants, and the L/J/O/U/I/K key codes (move these out of local defines).
- Add a cam_state_t enum to the same package.
- One natural sub-module: key_fifo (parameterised by KQ_DEPTH, 4-bit data, push/pop/full/empty/count).
- camera_rotator stays external; it is instantiated beside this block at the camera top.

Test Plan:
1. Reset release -> U = {3F800000,0,0}, V = {0,3F800000,0}, W = {0,0,3F800000}; all pulse outputs 0.
2. key=6 strobe at t, idle -> rot_key=6 at t+2; at t+3 W = {3F3504F3,0,3F3504F3}, U = {3F3504F3,0,BF3504F3}, V unchanged; cam_update=1 for one cycle.
3. frame_req granted (in_frame=1), then key=10 strobe -> U/V/W unchanged until frame_done; rotation commits 3 cycles after frame_done; a pending frame_req is granted on the IDLE cycle after that ROT.
4. In FRAME, 5 strobes of key=8 with KQ_DEPTH=4 -> key_drop pulses once, on the 5th; after frame_done exactly 4 rotations occur (U returns to identity after 8 total, so check intermediate values).
5. key=3 then key=6 then key=7 -> key 3 ignored (no pulse); basis after both rotations equals the reset basis; two cam_update pulses.
6. Force a non-lattice basis via the rotator model returning zeros for key=9 -> rot_err pulses, basis unchanged. Separately, assert rst during ROT -> basis at identity, FIFO empty, no cam_update.
